fc_seq_ctrl: RTL and testbench
==============================

// Module: fc_seq_ctrl
// PURPOSE
//  Job sequencer for fc_top: accepts one signed byte stream (valid/ready), scatters it into
//  fc_top's input, fc1 and fc2 weight write ports, pulses start, waits for done, returns
//  fc2_logit on a valid/ready result port. Optional weight reuse: input-only jobs.
// PARAMETERS
//  IN_LEN      132   input vector length (fc1 fan-in)
//  N_HID       10    fc1 neurons = fc2 fan-in
//  LOGIT_W     24    fc2_logit width
//  TIMEOUT_CYC 4096  max cycles from start pulse to done before abort
// PORTS
//  clk        in   1        clock
//  rst        in   1        async reset, active-high
//  s_valid    in   1        stream byte valid
//  s_ready    out  1        stream byte accepted when s_valid&s_ready
//  s_data     in   8        signed byte
//  keep_w     in   1        sampled with first byte of a job: 1 = stream carries input only
//  in_wr/in_addr[7:0]/in_data[7:0]               out  to fc_top input buffer
//  fc1_w_wr/fc1_w_addr[15:0]/fc1_w_data[7:0]     out  to fc_top fc1 weight RAM
//  fc2_w_wr/fc2_w_addr[3:0]/fc2_w_data[7:0]      out  to fc_top fc2 weight RAM
//  start      out  1        one-cycle compute pulse
//  done       in   1        fc_top completion
//  fc2_logit  in   LOGIT_W  fc_top result, valid while done=1
//  r_valid    out  1        result valid
//  r_ready    in   1        result accepted
//  r_logit    out  LOGIT_W  captured logit (0 on timeout)
//  r_timeout  out  1        1 = job aborted by timeout
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, weights_loaded=0. Reset mid-job aborts immediately; no
//   further writes; weights_loaded cleared so the next job forces a full load.
//  States: IDLE, LD_IN, LD_W1, LD_W2, START, WAIT, RESP.
//  s_ready=1 in IDLE/LD_IN/LD_W1/LD_W2, else 0.
//  IDLE: first accepted byte = in[0]; latch full = ~keep_w | ~weights_loaded; -> LD_IN.
//  Stream order: IN_LEN input bytes, then N_HID*IN_LEN fc1 bytes row-major
//   (addr = n*IN_LEN+i, generated by incrementing counter, no multiplier), then N_HID fc2 bytes.
//  Write timing: byte accepted in cycle t -> matching *_wr=1, addr, data registered in t+1;
//   one-cycle strobe, addresses strictly sequential from 0, no gaps/duplicates. Stalls
//   (s_valid=0) insert idle cycles, wr=0.
//  Last input byte: full ? -> LD_W1 : -> START. Last fc1 byte -> LD_W2. Last fc2 byte -> START,
//   weights_loaded<=1.
//  START: start=1 for exactly one cycle, the cycle after the final write strobe; -> WAIT.
//  WAIT: cycle counter from 1 after start. done=1 -> r_logit<=fc2_logit, r_timeout<=0.
//   Counter == TIMEOUT_CYC with done=0 -> r_logit<=0, r_timeout<=1. Either: r_valid<=1, -> RESP.
//   done and terminal count in same cycle: done wins.
//  done outside WAIT is ignored.
//  RESP: r_valid, r_logit, r_timeout held stable until r_valid&r_ready; then r_valid<=0,
//   -> IDLE (next job may start the cycle after).
//  keep_w ignored except on the first byte of a job.
// TESTING
//  1 Full load: in=(i%8)-3, fc1 w=n+1, fc2 w=1 into real fc_top -> 132/1320/10 sequential
//    writes, single start after last fc2 write, r_logit=3190 (fc1_out[n]=58*(n+1)), r_timeout=0.
//  2 Then keep_w=1, in all 1 -> only 132 bytes accepted, zero fc1/fc2 writes, r_logit=7260.
//  3 keep_w=1 right after reset -> full load performed (1462 bytes accepted), weights_loaded=1.
//  4 Random s_valid gaps and r_ready low 20 cycles -> writes only on accept+1, r_valid/r_logit
//    stable while held, s_ready=0 throughout START/WAIT/RESP.
//  5 TIMEOUT_CYC=64, done never asserted -> r_valid=1, r_timeout=1, r_logit=0 exactly 64
//    cycles after start pulse; done asserted at cycle 64 instead -> r_timeout=0.
//  6 rst mid LD_W1 after 500 fc1 bytes -> all outputs 0 asynchronously; next keep_w=1 job
//    performs full 1462-byte load.

Source files
------------

// File: rtl/fc_seq_ctrl.sv
// Job sequencer for fc_top: scatters one byte stream into the input, fc1 and fc2 write ports,
// launches the compute and returns the logit on a valid/ready port with a timeout guard.
module fc_seq_ctrl #(
    parameter int IN_LEN      = 132,
    parameter int N_HID       = 10,
    parameter int LOGIT_W     = 24,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_data,
    input  logic               keep_w,
    output logic               in_wr,
    output logic [7:0]         in_addr,
    output logic [7:0]         in_data,
    output logic               fc1_w_wr,
    output logic [15:0]        fc1_w_addr,
    output logic [7:0]         fc1_w_data,
    output logic               fc2_w_wr,
    output logic [3:0]         fc2_w_addr,
    output logic [7:0]         fc2_w_data,
    output logic               start,
    input  logic               done,
    input  logic [LOGIT_W-1:0] fc2_logit,
    output logic               r_valid,
    input  logic               r_ready,
    output logic [LOGIT_W-1:0] r_logit,
    output logic               r_timeout,
    output logic               busy
);

    // state | meaning
    // IDLE  | waiting for the first byte of a job
    // LD_IN | streaming input vector bytes
    // LD_W1 | streaming fc1 weights, row-major
    // LD_W2 | streaming fc2 weights
    // START | last write strobe in flight; start pulses next cycle
    // WAIT  | compute running, timeout timer counting down
    // RESP  | result held until accepted
    typedef enum logic [2:0] {IDLE, LD_IN, LD_W1, LD_W2, START, WAIT, RESP} state_t;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]    IN_LAST = 8'(IN_LEN - 1);
    localparam logic [15:0]   W1_LAST = 16'(N_HID * IN_LEN - 1);
    localparam logic [3:0]    W2_LAST = 4'(N_HID - 1);
    localparam logic [TW-1:0] T_LOAD  = TW'(TIMEOUT_CYC - 1);

    state_t        state;
    logic          weights_loaded;
    logic          full;
    logic [7:0]    in_cnt;
    logic [15:0]   w1_cnt;
    logic [3:0]    w2_cnt;
    logic [TW-1:0] tmr;
    logic          acc;

    assign acc  = s_valid & s_ready;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            weights_loaded <= 1'b0;
            full           <= 1'b0;
            in_cnt         <= '0;
            w1_cnt         <= '0;
            w2_cnt         <= '0;
            tmr            <= '0;
            s_ready        <= 1'b0;
            in_wr          <= 1'b0;
            in_addr        <= '0;
            in_data        <= '0;
            fc1_w_wr       <= 1'b0;
            fc1_w_addr     <= '0;
            fc1_w_data     <= '0;
            fc2_w_wr       <= 1'b0;
            fc2_w_addr     <= '0;
            fc2_w_data     <= '0;
            start          <= 1'b0;
            r_valid        <= 1'b0;
            r_logit        <= '0;
            r_timeout      <= 1'b0;
        end else begin
            in_wr    <= 1'b0;
            fc1_w_wr <= 1'b0;
            fc2_w_wr <= 1'b0;
            start    <= 1'b0;
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (acc) begin
                        in_wr   <= 1'b1;
                        in_addr <= 8'd0;
                        in_data <= s_data;
                        in_cnt  <= 8'd1;
                        w1_cnt  <= '0;
                        w2_cnt  <= '0;
                        full    <= ~keep_w | ~weights_loaded;
                        state   <= LD_IN;
                    end
                end
                LD_IN: begin
                    if (acc) begin
                        in_wr   <= 1'b1;
                        in_addr <= in_cnt;
                        in_data <= s_data;
                        in_cnt  <= in_cnt + 8'd1;
                        if (in_cnt == IN_LAST) begin
                            if (full) begin
                                state <= LD_W1;
                            end else begin
                                state   <= START;
                                s_ready <= 1'b0;
                            end
                        end
                    end
                end
                LD_W1: begin
                    if (acc) begin
                        fc1_w_wr   <= 1'b1;
                        fc1_w_addr <= w1_cnt;
                        fc1_w_data <= s_data;
                        w1_cnt     <= w1_cnt + 16'd1;
                        if (w1_cnt == W1_LAST) state <= LD_W2;
                    end
                end
                LD_W2: begin
                    if (acc) begin
                        fc2_w_wr   <= 1'b1;
                        fc2_w_addr <= w2_cnt;
                        fc2_w_data <= s_data;
                        w2_cnt     <= w2_cnt + 4'd1;
                        if (w2_cnt == W2_LAST) begin
                            state          <= START;
                            s_ready        <= 1'b0;
                            weights_loaded <= 1'b1;
                        end
                    end
                end
                START: begin
                    start <= 1'b1;
                    tmr   <= T_LOAD;
                    state <= WAIT;
                end
                WAIT: begin
                    // done has priority over the terminal count in the same cycle
                    if (done) begin
                        r_logit   <= fc2_logit;
                        r_timeout <= 1'b0;
                        r_valid   <= 1'b1;
                        state     <= RESP;
                    end else if (tmr == '0) begin
                        r_logit   <= '0;
                        r_timeout <= 1'b1;
                        r_valid   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                RESP: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Bench for fc_seq_ctrl: a stand-in fc_top built from the observed write strobes, plus a
// reference that computes the expected logit directly from each job's stream contents.
module tb_fc_seq_ctrl;
    localparam int IN_LEN  = 132;
    localparam int N_HID   = 10;
    localparam int LOGIT_W = 24;
    localparam int T       = 64;
    localparam int W1_N    = IN_LEN * N_HID;
    localparam int FULL_N  = IN_LEN + W1_N + N_HID;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic               s_ready;
    logic [7:0]         s_data;
    logic               keep_w;
    logic               in_wr;
    logic [7:0]         in_addr;
    logic [7:0]         in_data;
    logic               fc1_w_wr;
    logic [15:0]        fc1_w_addr;
    logic [7:0]         fc1_w_data;
    logic               fc2_w_wr;
    logic [3:0]         fc2_w_addr;
    logic [7:0]         fc2_w_data;
    logic               start;
    logic               done;
    logic [LOGIT_W-1:0] fc2_logit;
    logic               r_valid;
    logic               r_ready;
    logic [LOGIT_W-1:0] r_logit;
    logic               r_timeout;
    logic               busy;

    always #5 clk = ~clk;

    fc_seq_ctrl #(.IN_LEN(IN_LEN), .N_HID(N_HID), .LOGIT_W(LOGIT_W), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .keep_w(keep_w), .in_wr(in_wr), .in_addr(in_addr), .in_data(in_data),
        .fc1_w_wr(fc1_w_wr), .fc1_w_addr(fc1_w_addr), .fc1_w_data(fc1_w_data),
        .fc2_w_wr(fc2_w_wr), .fc2_w_addr(fc2_w_addr), .fc2_w_data(fc2_w_data),
        .start(start), .done(done), .fc2_logit(fc2_logit), .r_valid(r_valid),
        .r_ready(r_ready), .r_logit(r_logit), .r_timeout(r_timeout), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    logic signed [7:0] job_in[IN_LEN];
    logic signed [7:0] job_w1[W1_N];
    logic signed [7:0] job_w2[N_HID];
    logic signed [7:0] ref_w1[W1_N];
    logic signed [7:0] ref_w2[N_HID];
    logic signed [7:0] mem_in[IN_LEN];
    logic signed [7:0] mem_w1[W1_N];
    logic signed [7:0] mem_w2[N_HID];
    bit                ref_loaded = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Two-layer dot product; from_mem selects the stand-in fc_top RAMs, else the reference.
    function automatic logic [LOGIT_W-1:0] logit_of(input bit from_mem);
        longint acc = 0;
        longint h;
        for (int n = 0; n < N_HID; n++) begin
            h = 0;
            for (int i = 0; i < IN_LEN; i++)
                h += from_mem ? longint'(mem_in[i]) * longint'(mem_w1[n*IN_LEN+i])
                              : longint'(job_in[i]) * longint'(ref_w1[n*IN_LEN+i]);
            acc += h * (from_mem ? longint'(mem_w2[n]) : longint'(ref_w2[n]));
        end
        return acc[LOGIT_W-1:0];
    endfunction

    function automatic logic [7:0] byte_at(input int idx);
        if (idx < IN_LEN) return job_in[idx];
        if (idx < IN_LEN + W1_N) return job_w1[idx-IN_LEN];
        return job_w2[idx-IN_LEN-W1_N];
    endfunction

    task automatic fill_random();
        for (int i = 0; i < IN_LEN; i++) job_in[i] = 8'($urandom);
        for (int i = 0; i < W1_N; i++) job_w1[i] = 8'($urandom);
        for (int i = 0; i < N_HID; i++) job_w2[i] = 8'($urandom);
    endtask

    task automatic check_all_zero();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_wr", {in_wr, fc1_w_wr, fc2_w_wr, start}, 0);
        chk("rst_addr", {in_addr, fc1_w_addr, fc2_w_addr}, 0);
        chk("rst_data", {in_data, fc1_w_data, fc2_w_data}, 0);
        chk("rst_resp", {r_valid, r_timeout, busy}, 0);
        chk("rst_logit", r_logit, 0);
    endtask

    // Entered at a negedge with the DUT idle. done_at >= T means done is never raised.
    task automatic run_job(input bit keep, input int gap_pct, input int hold,
                           input int done_at, input int abort_at);
        bit full = !keep || !ref_loaded;
        int total = full ? FULL_N : IN_LEN;
        int idx = 0;
        int after = -1;
        int budget = 0;
        int pend = -1;
        int resp;
        bit rdy;
        bit to;
        logic [LOGIT_W-1:0] hw;
        logic [LOGIT_W-1:0] exp_logit;

        while (after != 1 && budget < 20000) begin
            chk("s_ready_load", s_ready, idx < total);
            chk("start_early", start, 0);
            chk("in_wr", in_wr, pend >= 0 && pend < IN_LEN);
            chk("fc1_w_wr", fc1_w_wr, pend >= IN_LEN && pend < IN_LEN + W1_N);
            chk("fc2_w_wr", fc2_w_wr, pend >= IN_LEN + W1_N);
            if (pend >= 0 && pend < IN_LEN) begin
                chk("in_addr", in_addr, pend);
                chk("in_data", in_data, byte_at(pend));
            end else if (pend >= IN_LEN && pend < IN_LEN + W1_N) begin
                chk("fc1_w_addr", fc1_w_addr, pend - IN_LEN);
                chk("fc1_w_data", fc1_w_data, byte_at(pend));
            end else if (pend >= IN_LEN + W1_N) begin
                chk("fc2_w_addr", fc2_w_addr, pend - IN_LEN - W1_N);
                chk("fc2_w_data", fc2_w_data, byte_at(pend));
            end
            if (in_wr && int'(in_addr) < IN_LEN) mem_in[in_addr] = in_data;
            if (fc1_w_wr && int'(fc1_w_addr) < W1_N) mem_w1[fc1_w_addr] = fc1_w_data;
            if (fc2_w_wr && int'(fc2_w_addr) < N_HID) mem_w2[fc2_w_addr] = fc2_w_data;
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b1;
                s_valid = 1'b0;
                done = 1'b0;
                #1;
                check_all_zero();
                @(negedge clk);
                rst = 1'b0;
                ref_loaded = 1'b0;
                @(negedge clk);
                return;
            end
            rdy = s_ready;
            s_valid = (idx < total) && ($urandom_range(99) >= gap_pct);
            s_data = s_valid ? byte_at(idx) : 8'($urandom);
            keep_w = (idx == 0) ? keep : 1'($urandom);
            done = ($urandom_range(99) < 5);
            fc2_logit = LOGIT_W'($urandom);
            r_ready = 1'($urandom);
            @(negedge clk);
            budget++;
            pend = -1;
            if (s_valid && rdy) begin
                pend = idx;
                idx++;
                if (idx == total) after = 0;
            end else if (after >= 0) begin
                after++;
            end
        end
        s_valid = 1'b0;
        checks++;
        assert (after == 1) else begin
            errors++;
            $error("FAIL load_budget observed=%0d bytes expected=%0d", idx, total);
            return;
        end

        chk("start", start, 1);
        if (full) begin
            ref_w1 = job_w1;
            ref_w2 = job_w2;
            ref_loaded = 1'b1;
        end
        exp_logit = logit_of(1'b0);
        hw = logit_of(1'b1);
        to = (done_at >= T);
        resp = to ? T : done_at + 1;
        for (int k = 0; k <= resp; k++) begin
            if (k > 0) chk("start_once", start, 0);
            chk("s_ready_busy", s_ready, 0);
            chk("busy", busy, 1);
            chk("r_valid_rise", r_valid, k == resp);
            chk("wr_idle", {in_wr, fc1_w_wr, fc2_w_wr}, 0);
            if (k == resp) break;
            done = (k == done_at);
            fc2_logit = done ? hw : LOGIT_W'($urandom);
            r_ready = 1'($urandom);
            @(negedge clk);
        end
        done = 1'b0;
        r_ready = 1'b0;
        if (!to) chk("written_model", hw, exp_logit);
        chk("r_logit", r_logit, to ? 0 : exp_logit);
        chk("r_timeout", r_timeout, to);
        for (int h = 0; h < hold; h++) begin
            s_valid = 1'($urandom);
            done = 1'($urandom);
            @(negedge clk);
            chk("hold_r_valid", r_valid, 1);
            chk("hold_r_logit", r_logit, to ? 0 : exp_logit);
            chk("hold_r_timeout", r_timeout, to);
            chk("hold_s_ready", s_ready, 0);
        end
        s_valid = 1'b0;
        done = 1'b0;
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        chk("r_valid_drop", r_valid, 0);
        chk("busy_idle", busy, 0);
        chk("s_ready_idle", s_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        keep_w = 1'b0;
        done = 1'b0;
        fc2_logit = '0;
        r_ready = 1'b0;
        #2;
        check_all_zero();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // keep_w=1 straight after reset must still force a full load
        for (int i = 0; i < IN_LEN; i++) job_in[i] = 8'((i % 8) - 3);
        for (int n = 0; n < N_HID; n++)
            for (int i = 0; i < IN_LEN; i++) job_w1[n*IN_LEN+i] = 8'(n + 1);
        for (int n = 0; n < N_HID; n++) job_w2[n] = 8'd1;
        run_job(1'b1, 0, 0, 5, -1);
        chk("job1_logit", r_logit, 3190);

        // weight reuse: input-only job
        for (int i = 0; i < IN_LEN; i++) job_in[i] = 8'd1;
        for (int i = 0; i < W1_N; i++) job_w1[i] = 8'($urandom);
        run_job(1'b1, 10, 3, 7, -1);
        chk("job2_logit", r_logit, 7260);

        // random data, stream gaps, result held off for 20 cycles
        fill_random();
        run_job(1'b0, 30, 20, $urandom_range(1, 20), -1);

        // timeout with done never raised, then done exactly at the terminal count
        fill_random();
        run_job(1'b1, 0, 2, 1000, -1);
        fill_random();
        run_job(1'b1, 20, 1, T - 1, -1);

        // reset after 500 fc1 bytes, then a keep_w=1 job must reload everything
        fill_random();
        run_job(1'b0, 10, 0, 3, IN_LEN + 500);
        fill_random();
        run_job(1'b1, 15, 2, $urandom_range(1, 30), -1);

        for (int j = 0; j < 3; j++) begin
            fill_random();
            run_job(1'($urandom), $urandom_range(0, 40), $urandom_range(0, 5),
                    $urandom_range(1, T + 5), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
